// File: rtl/param_register_file_pkg.sv
// Shared types and defaults for the parametrised register file and the decode stage.
package regfile_pkg;

   typedef enum logic {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_t;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 6;

   function automatic int rf_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/param_register_file_if.sv
// Decode/writeback side bus of the register file: one write port, NUM_RD read ports.
interface param_register_file_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = 2
);

   logic                       wr_en;
   logic [ADDR_W-1:0]          wr_addr;
   logic [DATA_W-1:0]          wr_data;
   logic [NUM_RD-1:0]          rd_en;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic [NUM_RD-1:0]          rd_valid;
   logic                       ready;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, rd_valid, ready
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, rd_valid, ready
   );

endinterface

// File: rtl/param_register_file_rd_port.sv
// One registered read port: zero-register / bypass / memory select, plus valid strobe.
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              wr_eff_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o
);

   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   // Select the read value; data holds when the port is idle or the file is clearing
   always_comb begin
      rd_valid_d = run_i && rd_en_i;
      rd_data_d  = rd_data_q;
      if (run_i && rd_en_i) begin
         if (ZERO_REG && (rd_addr_i == '0))
            rd_data_d = '0;
         else if (BYPASS && wr_eff_i && (wr_addr_i == rd_addr_i))
            rd_data_d = wr_data_i;
         else
            rd_data_d = mem_data_i;
      end
   end

   // Output registers, cleared by reset so consumers never see stale data
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: memory, write port and post-reset clear FSM; read ports as sub-modules.
module param_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   param_register_file_if.slave bus
);

   localparam int DEPTH = rf_depth(ADDR_W);

   rf_state_t         state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              run, clr_we, wr_eff;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_a  [NUM_RD];
   logic              rd_valid_a [NUM_RD];

   // FSM state and clear pointer; reset restarts the clear from entry 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RF_CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // Walk every entry once, then enter run on the edge that clears the last one
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (state_q == RF_CLEAR) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         if (clr_ptr_q == {ADDR_W{1'b1}})
            state_d = RF_RUN;
      end
   end

   // Decode FSM state into datapath controls; writes to a hard-wired zero entry are dropped
   always_comb begin
      run    = (state_q == RF_RUN);
      clr_we = (state_q == RF_CLEAR);
      wr_eff = run && bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
   end

   // Storage: no reset of its own, the clear sequence zeroes it after reset is released
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we)
            mem_q[clr_ptr_q] <= '0;
         else if (wr_eff)
            mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

      rf_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_port (
         .clk        (clk),
         .rst        (rst),
         .run_i      (run),
         .rd_en_i    (bus.rd_en[i]),
         .rd_addr_i  (addr),
         .mem_data_i (mem_q[addr]),
         .wr_eff_i   (wr_eff),
         .wr_addr_i  (bus.wr_addr),
         .wr_data_i  (bus.wr_data),
         .rd_data_o  (rd_data_a[i]),
         .rd_valid_o (rd_valid_a[i])
      );
   end

   // Pack per-port results onto the flat bus
   always_comb begin
      bus.rd_data  = '0;
      bus.rd_valid = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         bus.rd_data[i*DATA_W +: DATA_W] = rd_data_a[i];
         bus.rd_valid[i]                 = rd_valid_a[i];
      end
   end

   assign bus.ready = run;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: default file (bypass, no zero reg) alongside a read-first, zero-register variant.
module tb_param_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  rd_en;
   logic [11:0] rd_addr;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   param_register_file_if #(.DATA_W(32), .ADDR_W(6), .NUM_RD(2)) ifa ();
   param_register_file_if #(.DATA_W(32), .ADDR_W(6), .NUM_RD(2)) ifb ();

   assign ifa.wr_en   = wr_en;
   assign ifa.wr_addr = wr_addr;
   assign ifa.wr_data = wr_data;
   assign ifa.rd_en   = rd_en;
   assign ifa.rd_addr = rd_addr;
   assign ifb.wr_en   = wr_en;
   assign ifb.wr_addr = wr_addr;
   assign ifb.wr_data = wr_data;
   assign ifb.rd_en   = rd_en;
   assign ifb.rd_addr = rd_addr;

   param_register_file #(
      .DATA_W(32), .ADDR_W(6), .NUM_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b1)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   param_register_file #(
      .DATA_W(32), .ADDR_W(6), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic en, input logic [5:0] a, input logic [31:0] d);
      wr_en   = en;
      wr_addr = a;
      wr_data = d;
   endtask

   task automatic rd(input logic [1:0] en, input logic [5:0] a1, input logic [5:0] a0);
      rd_en   = en;
      rd_addr = {a1, a0};
   endtask

   // Wait for ready after a reset release; a write and reads are attempted mid-clear
   task automatic wait_ready(input string tag);
      int cyc;
      cyc = 0;
      while (!ifa.ready && cyc < 80) begin
         if (cyc == 40) begin
            wr(1'b1, 6'd2, 32'h0000_0055);
            rd(2'b11, 6'd2, 6'd2);
         end else begin
            wr(1'b0, 6'd0, 32'h0);
            rd(2'b00, 6'd0, 6'd0);
         end
         step();
         cyc++;
         if (cyc == 41) begin
            check_val({tag, "_clr_vld_a"}, 64'(ifa.rd_valid), 64'd0);
            check_val({tag, "_clr_dat_a"}, 64'(ifa.rd_data), 64'd0);
         end
      end
      check_val({tag, "_lat"}, 64'(cyc), 64'd64);
      check_val({tag, "_rdy_b"}, 64'(ifb.ready), 64'd1);
      wr(1'b0, 6'd0, 32'h0);
      rd(2'b00, 6'd0, 6'd0);
   endtask

   initial begin
      rst = 1'b1;
      wr(1'b0, 6'd0, 32'h0);
      rd(2'b00, 6'd0, 6'd0);
      step();
      step();
      check_val("rst_ready", 64'(ifa.ready), 64'd0);
      check_val("rst_valid", 64'(ifa.rd_valid), 64'd0);
      check_val("rst_data", 64'(ifa.rd_data), 64'd0);

      // first clear interrupted at step 30
      rst = 1'b0;
      for (int i = 0; i < 30; i++) step();
      check_val("clr30_ready", 64'(ifa.ready), 64'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_ready("clr1");

      // every entry reads zero after clear, including the dropped write to 2
      for (int i = 0; i < 64; i++) begin
         rd(2'b11, 6'(63 - i), 6'(i));
         step();
         check_val("sweep_a", 64'(ifa.rd_data), 64'd0);
         check_val("sweep_b", 64'(ifb.rd_data), 64'd0);
      end
      check_val("sweep_vld", 64'(ifa.rd_valid), 64'd3);

      // basic write then read
      rd(2'b00, 6'd0, 6'd0);
      wr(1'b1, 6'd5, 32'hDEAD_BEEF);
      step();
      wr(1'b0, 6'd0, 32'h0);
      rd(2'b01, 6'd0, 6'd5);
      step();
      check_val("basic_a", 64'(ifa.rd_data[31:0]), 64'hDEAD_BEEF);
      check_val("basic_vld", 64'(ifa.rd_valid), 64'd1);
      check_val("basic_b", 64'(ifb.rd_data[31:0]), 64'hDEAD_BEEF);

      // same-cycle write/read conflict
      rd(2'b00, 6'd0, 6'd0);
      wr(1'b1, 6'd9, 32'h11);
      step();
      wr(1'b1, 6'd9, 32'h22);
      rd(2'b01, 6'd0, 6'd9);
      step();
      check_val("byp_a", 64'(ifa.rd_data[31:0]), 64'h22);
      check_val("nobyp_b", 64'(ifb.rd_data[31:0]), 64'h11);
      wr(1'b0, 6'd0, 32'h0);
      step();
      check_val("after_a", 64'(ifa.rd_data[31:0]), 64'h22);
      check_val("after_b", 64'(ifb.rd_data[31:0]), 64'h22);

      // zero register
      rd(2'b00, 6'd0, 6'd0);
      wr(1'b1, 6'd0, 32'hFFFF_FFFF);
      step();
      wr(1'b0, 6'd0, 32'h0);
      rd(2'b11, 6'd0, 6'd0);
      step();
      check_val("zero_a", 64'(ifa.rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
      check_val("zero_b", 64'(ifb.rd_data), 64'h0);
      check_val("zero_vld_b", 64'(ifb.rd_valid), 64'd3);

      // dual ports, then hold
      rd(2'b00, 6'd0, 6'd0);
      wr(1'b1, 6'd3, 32'hA);
      step();
      wr(1'b1, 6'd4, 32'hB);
      step();
      wr(1'b0, 6'd0, 32'h0);
      rd(2'b11, 6'd4, 6'd3);
      step();
      check_val("dual_a", 64'(ifa.rd_data), 64'h0000_000B_0000_000A);
      check_val("dual_b", 64'(ifb.rd_data), 64'h0000_000B_0000_000A);
      rd(2'b00, 6'd0, 6'd0);
      step();
      check_val("hold_vld", 64'(ifa.rd_valid), 64'd0);
      check_val("hold_a", 64'(ifa.rd_data), 64'h0000_000B_0000_000A);

      // both ports on one address
      rd(2'b11, 6'd5, 6'd5);
      step();
      check_val("same_a", 64'(ifa.rd_data), 64'hDEAD_BEEF_DEAD_BEEF);

      // reset mid-run re-clears everything
      rd(2'b00, 6'd0, 6'd0);
      rst = 1'b1;
      step();
      check_val("rr_ready", 64'(ifa.ready), 64'd0);
      check_val("rr_valid", 64'(ifa.rd_valid), 64'd0);
      check_val("rr_data", 64'(ifa.rd_data), 64'd0);
      rst = 1'b0;
      wait_ready("clr2");
      rd(2'b11, 6'd9, 6'd5);
      step();
      check_val("reclr_a", 64'(ifa.rd_data), 64'd0);
      check_val("reclr_vld", 64'(ifa.rd_valid), 64'd3);
      rd(2'b11, 6'd3, 6'd2);
      step();
      check_val("reclr_b", 64'(ifb.rd_data), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the project's 64x32 register file.
- Generalised in data width, depth and number of read ports.
- Adds a synchronous reset that runs a clear sequence over all entries, registered reads with a valid strobe, selectable write-to-read bypass, and an optional hard-wired zero register.
- Sits between decode (read addresses) and writeback (write port) in the CPU datapath.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 0, when 1, entry 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, when 1, a same-cycle write to the read address is forwarded (write-first); when 0, the read returns the pre-write value (read-first).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_en  in  NUM_RD  per-port read strobe.
- rd_addr  in  NUM_RD*ADDR_W  port i address in bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  port i data in bits [i*DATA_W +: DATA_W]; registered.
- rd_valid  out  NUM_RD  port i data updated this cycle.
- ready  out  1  clear sequence done; block accepts reads and writes.

Behaviour:
- Reset is synchronous, active-high, on clk; no asynchronous path.
- FSM states RF_CLEAR and RF_RUN, with a clear pointer clr_ptr of width ADDR_W.
- Posedge with rst=1:
  - state <= RF_CLEAR, clr_ptr <= 0.
  - ready <= 0, rd_valid <= 0, rd_data <= 0.
  - Memory is not touched on this edge.
- RF_CLEAR, rst=0, each posedge:
  - mem[clr_ptr] <= 0, clr_ptr <= clr_ptr+1.
  - When clr_ptr == DEPTH-1: state <= RF_RUN and ready <= 1 on that same edge.
  - ready therefore rises on the DEPTH-th posedge after rst falls (64 for defaults).
  - wr_en and rd_en are ignored; rd_valid stays 0; rd_data holds 0.
- Reset mid-clear restarts the sequence at entry 0; reset mid-run re-clears all entries.
- RF_RUN write:
  - Effective write = wr_en && !(ZERO_REG && wr_addr==0).
  - On an effective write, mem[wr_addr] <= wr_data at posedge.
- RF_RUN read, per port i, at posedge:
  - rd_valid[i] <= rd_en[i].
  - If rd_en[i]=1, rd_data[i] is loaded by priority:
    - 0 if ZERO_REG && addr==0;
    - otherwise wr_data if BYPASS && effective write && wr_addr==addr;
    - otherwise mem[addr] (pre-edge contents).
  - If rd_en[i]=0, rd_data[i] holds its previous value.
- Latency: one cycle from address to rd_data. A write is visible to a read issued in the same cycle only when BYPASS=1, and to any later read regardless.
- Multiple ports may read the same address in the same cycle; all return identical data.
- Single write port, so no write-write conflict exists.
- Address arithmetic: clr_ptr wraps naturally at DEPTH; no address can be out of range since DEPTH = 2**ADDR_W.

Decomposition:
- Package regfile_pkg holds:
  - rf_state_t enum {RF_CLEAR, RF_RUN};
  - function rf_depth(addr_w) returning 2**addr_w;
  - default DATA_W/ADDR_W constants shared with the decode stage.
- One sub-module, rf_read_port, instantiated NUM_RD times via generate. It holds the registered rd_data/rd_valid plus the zero/bypass mux; the top level owns the memory array, write logic and clear FSM.

Test Plan:
- Reset then clear: rst high 2 cycles, then low -> ready=0 for cycles 1..63 after rst falls, ready=1 at cycle 64. Any read afterwards returns 0x00000000 for every entry.
- Basic write/read: write 0xDEADBEEF to addr 5; next cycle rd_en[0]=1, addr 5 -> rd_data[0]=0xDEADBEEF and rd_valid[0]=1 one cycle later.
- Same-cycle conflict: mem[9]=0x11 and, in the same cycle, write 0x22 to addr 9 while reading addr 9 -> BYPASS=1 returns 0x22; BYPASS=0 returns 0x11, and a read the next cycle returns 0x22.
- Zero register: with ZERO_REG=1, write 0xFFFF_FFFF to addr 0, then read addr 0 on both ports -> 0x0. With ZERO_REG=0 the same sequence returns 0xFFFF_FFFF.
- Dual ports and hold: port0 reads addr 3 (0xA), port1 reads addr 4 (0xB) simultaneously -> both correct. Then drop rd_en -> rd_valid=0 and rd_data holds 0xA/0xB.
- Reset mid-operation: assert rst at clear step 30 -> restart; the ready edge comes 64 cycles after the second rst release. A write attempted during clear to addr 2 is dropped and addr 2 reads 0 after ready.
